// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command controller and its
// inter-byte timeout helper.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    HUNT,
    CMD,
    DATA,
    CHK,
    APPLY
  } state_t;

  typedef enum logic {
    REQ,
    CAP
  } phase_t;

  localparam logic [7:0]  CMD_SET_DVSR     = 8'h01;
  localparam logic [7:0]  CMD_RESTORE      = 8'h02;
  localparam logic [7:0]  DEFAULT_SYNC     = 8'h55;
  localparam int unsigned FRAME_DATA_BYTES = 4;

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter: counts enabled cycles, clears on a captured
// byte, and pulses expire on the LIMIT-th consecutive enabled cycle.
module uart_cmd_timer #(
  parameter int unsigned LIMIT = 200000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt;

  assign expire = en && (cnt == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || expire) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Pops RX FIFO bytes, parses SYNC/CMD/D0..D3/CHK frames and rewrites the
// baud divisor. Define UART_CMD_TIMEOUT_EN to abort stalled frames.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned DVSR_W       = 32,
  parameter int unsigned DVSR_DEFAULT = 53,
  parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC,
  parameter int unsigned TIMEOUT_CYC  = 200000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [7:0]        fifo_data,
  output logic              fifo_rd_en,
  output logic [DVSR_W-1:0] dvsr,
  output logic              cfg_update,
  output logic              err_chk,
  output logic              err_cmd,
  output logic              err_tmo,
  output logic              busy
);

  localparam logic [DVSR_W-1:0] DVSR_RST = DVSR_W'(DVSR_DEFAULT);
  localparam logic [1:0]        LAST_IDX = 2'(FRAME_DATA_BYTES - 1);

  state_t            state;
  phase_t            phase;
  logic [7:0]        cmd;
  logic [7:0]        xsum;
  logic [1:0]        cnt;
  logic [31:0]       shadow;
  logic [DVSR_W-1:0] dvsr_new;
  logic              tmo_expire;

  if (DVSR_W > 32) begin : g_dvsr_ext
    assign dvsr_new = {{(DVSR_W - 32){1'b0}}, shadow};
  end else begin : g_dvsr_trunc
    assign dvsr_new = shadow[DVSR_W-1:0];
  end

  assign busy = (state != HUNT);

`ifdef UART_CMD_TIMEOUT_EN
  // Only count while mid-frame and genuinely starved (no pop in flight).
  uart_cmd_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (phase == CAP),
    .en     ((state inside {CMD, DATA, CHK}) && (phase == REQ) &&
             fifo_empty && !fifo_rd_en),
    .expire (tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
  if (TIMEOUT_CYC == 0) begin : g_tmo_unused
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      phase      <= REQ;
      fifo_rd_en <= 1'b0;
      cmd        <= '0;
      xsum       <= '0;
      cnt        <= '0;
      shadow     <= '0;
      dvsr       <= DVSR_RST;
      cfg_update <= 1'b0;
      err_chk    <= 1'b0;
      err_cmd    <= 1'b0;
      err_tmo    <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      cfg_update <= 1'b0;
      err_chk    <= 1'b0;
      err_cmd    <= 1'b0;
      err_tmo    <= 1'b0;

      // A new pop may be requested in the CAP cycle, giving one byte per 2 clk.
      case (phase)
        REQ: begin
          if (fifo_rd_en) begin
            phase <= CAP;
          end else if (!fifo_empty) begin
            fifo_rd_en <= 1'b1;
          end
        end
        CAP: begin
          phase <= REQ;
          if (!fifo_empty) fifo_rd_en <= 1'b1;
        end
        default: phase <= REQ;
      endcase

      if (tmo_expire) begin
        state   <= HUNT;
        err_tmo <= 1'b1;
        cnt     <= '0;
        xsum    <= '0;
        shadow  <= '0;
      end else if (state == APPLY) begin
        dvsr       <= (cmd == CMD_SET_DVSR) ? dvsr_new : DVSR_RST;
        cfg_update <= 1'b1;
        state      <= HUNT;
      end else if (phase == CAP) begin
        case (state)
          HUNT: begin
            if (fifo_data == SYNC_BYTE) state <= CMD;
          end
          CMD: begin
            cmd   <= fifo_data;
            xsum  <= fifo_data;
            cnt   <= '0;
            state <= DATA;
          end
          DATA: begin
            shadow[8*cnt +: 8] <= fifo_data;
            xsum               <= xsum ^ fifo_data;
            cnt                <= cnt + 2'd1;
            if (cnt == LAST_IDX) state <= CHK;
          end
          CHK: begin
            if (fifo_data != xsum) begin
              err_chk <= 1'b1;
              state   <= HUNT;
            end else if (cmd == CMD_SET_DVSR || cmd == CMD_RESTORE) begin
              state <= APPLY;
            end else begin
              err_cmd <= 1'b1;
              state   <= HUNT;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: bytes go into a modelled RX FIFO,
// expected pulses into a queue checked by an independent monitor.
module tb_uart_cmd_ctrl;

  typedef enum logic [1:0] {EV_CFG, EV_CHK, EV_CMD, EV_TMO} ev_kind_t;
  typedef struct packed {
    ev_kind_t    kind;
    logic [31:0] dvsr;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data = '0;
  logic        fifo_rd_en;
  logic [31:0] dvsr;
  logic        cfg_update;
  logic        err_chk;
  logic        err_cmd;
  logic        err_tmo;
  logic        busy;

  logic [7:0]  rxq[$];
  ev_t         expq[$];
  int          checks = 0;
  int          errors = 0;

  uart_cmd_ctrl #(
    .DVSR_W      (32),
    .DVSR_DEFAULT(53),
    .SYNC_BYTE   (8'h55),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .dvsr      (dvsr),
    .cfg_update(cfg_update),
    .err_chk   (err_chk),
    .err_cmd   (err_cmd),
    .err_tmo   (err_tmo),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // RX FIFO model: data appears the cycle after the pop strobe.
  always @(posedge clk) begin
    if (rst_n && fifo_rd_en) begin
      checks++;
      if (rxq.size() == 0) begin
        errors++;
        $display("FAIL rd_on_empty: fifo_rd_en=1 with model FIFO empty, required no pop");
      end else begin
        fifo_data <= rxq.pop_front();
      end
    end
  end

  always @(negedge clk) fifo_empty <= (rxq.size() == 0);

  // Monitor: every pulse must match the head of the expected queue.
  logic        prev_rd = 1'b0;
  logic [31:0] prev_dvsr = 32'd53;
  always @(negedge clk) begin
    int       npulse;
    ev_t      e;
    ev_kind_t act;
    if (rst_n) begin
      if (fifo_rd_en) begin
        checks++;
        if (prev_rd) begin
          errors++;
          $display("FAIL rd_spacing: fifo_rd_en high two cycles in a row, required gap");
        end
      end
      npulse = int'(cfg_update) + int'(err_chk) + int'(err_cmd) + int'(err_tmo);
      if (npulse != 0) begin
        checks++;
        act = cfg_update ? EV_CFG : err_chk ? EV_CHK : err_cmd ? EV_CMD : EV_TMO;
        if (npulse > 1) begin
          errors++;
          $display("FAIL pulse_multi: %0d pulses at once, required 1", npulse);
        end else if (expq.size() == 0) begin
          errors++;
          $display("FAIL pulse_unexpected: kind=%0d dvsr=%h, required no pulse", act, dvsr);
        end else begin
          e = expq.pop_front();
          if (act != e.kind || dvsr != e.dvsr) begin
            errors++;
            $display("FAIL pulse_event: kind=%0d dvsr=%h, required kind=%0d dvsr=%h",
                     act, dvsr, e.kind, e.dvsr);
          end
        end
      end
      if (dvsr != prev_dvsr) begin
        checks++;
        if (!cfg_update) begin
          errors++;
          $display("FAIL dvsr_silent: dvsr %h->%h without cfg_update", prev_dvsr, dvsr);
        end
      end
      prev_rd   = fifo_rd_en;
      prev_dvsr = dvsr;
    end else begin
      prev_rd   = 1'b0;
      prev_dvsr = dvsr;
    end
  end

  task automatic push_seq(input logic [95:0] v, input int n);
    for (int i = 0; i < n; i++) rxq.push_back(v[8*(n-1-i) +: 8]);
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.dvsr = d;
    expq.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((rxq.size() != 0 || busy || expq.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s_drain: timed out with %0d bytes, %0d events pending, busy=%0b, required idle",
               name, rxq.size(), expq.size(), busy);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_dvsr", dvsr, 32'd53);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_pulses", {28'd0, cfg_update, err_chk, err_cmd, err_tmo}, 32'd0);

    expect_ev(EV_CFG, 32'h0001_86A0);
    push_seq(56'h55_01_A0_86_01_00_26, 7);
    drain("set_dvsr");
    check("set_dvsr_val", dvsr, 32'h0001_86A0);

    expect_ev(EV_CMD, 32'h0001_86A0);
    push_seq(80'h12_55_55_01_00_00_00_54_26_33, 10);
    expect_ev(EV_CFG, 32'd53);
    push_seq(56'h55_02_00_00_00_00_02, 7);
    drain("resync");
    check("resync_restore", dvsr, 32'd53);

    expect_ev(EV_CHK, 32'd53);
    push_seq(56'h55_01_10_00_00_00_FF, 7);
    drain("bad_chk");
    check("bad_chk_dvsr", dvsr, 32'd53);
    check("bad_chk_busy", {31'd0, busy}, 32'd0);

    expect_ev(EV_CMD, 32'd53);
    push_seq(56'h55_07_00_00_00_00_07, 7);
    drain("bad_cmd");
    check("bad_cmd_dvsr", dvsr, 32'd53);

    expect_ev(EV_CFG, 32'd0);
    push_seq(56'h55_01_00_00_00_00_01, 7);
    expect_ev(EV_CFG, 32'd53);
    push_seq(56'h55_02_11_22_33_44_46, 7);
    expect_ev(EV_CFG, 32'h0000_5555);
    push_seq(56'h55_01_55_55_00_00_01, 7);
    drain("zero_restore_sync_data");
    check("sync_as_data", dvsr, 32'h0000_5555);

`ifdef UART_CMD_TIMEOUT_EN
    expect_ev(EV_TMO, 32'h0000_5555);
`endif
    push_seq(24'h55_01_A0, 3);
    repeat (1000) @(negedge clk);
`ifdef UART_CMD_TIMEOUT_EN
    check("tmo_busy", {31'd0, busy}, 32'd0);
    check("tmo_seen", expq.size(), 32'd0);
`else
    check("starve_busy", {31'd0, busy}, 32'd1);
`endif
    check("starve_dvsr", dvsr, 32'h0000_5555);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_dvsr", dvsr, 32'd53);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    expect_ev(EV_CFG, 32'h0000_1234);
    push_seq(56'h55_01_34_12_00_00_27, 7);
    drain("post_rst");
    check("post_rst_dvsr", dvsr, 32'h0000_1234);
    check("queue_empty", expq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
